// File: rtl/clock_alarm_pkg.sv
// Shared constants and helpers for the 24-hour alarm clock: segment patterns,
// counter limits, wrap-increment and binary-to-digit split.
package clock_alarm_pkg;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}.
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [5:0] HR_MAX  = 6'd23;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] bcd_units(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

endpackage

// File: rtl/clock_alarm_seg7_decoder.sv
// One 7-segment digit decoder; non-decimal inputs blank the digit.
module seg7_decoder
    import clock_alarm_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/clock_alarm.sv
// 24-hour HH:MM:SS clock with one HH:MM alarm, button-style time/alarm setting
// and six active-low 7-segment digit outputs.
module clock_alarm
    import clock_alarm_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic Set_Clock,
    input  logic Set_Alarm,
    input  logic Alarm_Off,
    input  logic MIN,
    input  logic HR,
    output logic a_s_u, b_s_u, c_s_u, d_s_u, e_s_u, f_s_u, g_s_u,
    output logic a_s_t, b_s_t, c_s_t, d_s_t, e_s_t, f_s_t, g_s_t,
    output logic a_m_u, b_m_u, c_m_u, d_m_u, e_m_u, f_m_u, g_m_u,
    output logic a_m_t, b_m_t, c_m_t, d_m_t, e_m_t, f_m_t, g_m_t,
    output logic a_h_u, b_h_u, c_h_u, d_h_u, e_h_u, f_h_u, g_h_u,
    output logic a_h_t, b_h_t, c_h_t, d_h_t, e_h_t, f_h_t, g_h_t,
    output logic Alarm
);

    localparam int unsigned    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic [5:0]    al_min_q, al_min_d, al_hr_q, al_hr_d;
    logic          min_prev_q, hr_prev_q;
    logic          alarm_q, alarm_d;

    logic          tick, min_edge, hr_edge, show_alarm;
    logic [5:0]    disp_sec, disp_min, disp_hr;

    assign min_edge   = MIN & ~min_prev_q;
    assign hr_edge    = HR & ~hr_prev_q;
    assign tick       = ~Set_Clock && (presc_q == PRESC_LAST);
    assign show_alarm = Set_Alarm & ~Set_Clock;

    always_comb begin
        presc_d  = presc_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hr_d     = hr_q;
        al_min_d = al_min_q;
        al_hr_d  = al_hr_q;
        alarm_d  = alarm_q;

        if (Set_Clock || tick) presc_d = '0;
        else                   presc_d = presc_q + PRESC_ONE;

        if (Set_Clock) begin
            sec_d = 6'd0;
            if (min_edge) min_d = wrap_inc(min_q, MIN_MAX);
            if (hr_edge)  hr_d  = wrap_inc(hr_q, HR_MAX);
        end else begin
            if (tick) begin
                sec_d = wrap_inc(sec_q, SEC_MAX);
                if (sec_q == SEC_MAX) begin
                    min_d = wrap_inc(min_q, MIN_MAX);
                    if (min_q == MIN_MAX) hr_d = wrap_inc(hr_q, HR_MAX);
                end
            end
            if (Set_Alarm) begin
                if (min_edge) al_min_d = wrap_inc(al_min_q, MIN_MAX);
                if (hr_edge)  al_hr_d  = wrap_inc(al_hr_q, HR_MAX);
            end
        end

        // Only a running tick can ring, so time edits landing on the alarm stay silent.
        if (Alarm_Off)
            alarm_d = 1'b0;
        else if (tick && sec_d == 6'd0 && min_d == al_min_q && hr_d == al_hr_q)
            alarm_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hr_q       <= 6'd0;
            al_min_q   <= 6'd0;
            al_hr_q    <= 6'd0;
            min_prev_q <= 1'b0;
            hr_prev_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            al_min_q   <= al_min_d;
            al_hr_q    <= al_hr_d;
            min_prev_q <= MIN;
            hr_prev_q  <= HR;
            alarm_q    <= alarm_d;
        end
    end

    assign Alarm    = alarm_q;
    assign disp_sec = show_alarm ? 6'd0     : sec_q;
    assign disp_min = show_alarm ? al_min_q : min_q;
    assign disp_hr  = show_alarm ? al_hr_q  : hr_q;

    logic [6:0] seg_su, seg_st, seg_mu, seg_mt, seg_hu, seg_ht;

    seg7_decoder u_dec_su (.bcd_i(bcd_units(disp_sec)), .seg_o(seg_su));
    seg7_decoder u_dec_st (.bcd_i(bcd_tens(disp_sec)),  .seg_o(seg_st));
    seg7_decoder u_dec_mu (.bcd_i(bcd_units(disp_min)), .seg_o(seg_mu));
    seg7_decoder u_dec_mt (.bcd_i(bcd_tens(disp_min)),  .seg_o(seg_mt));
    seg7_decoder u_dec_hu (.bcd_i(bcd_units(disp_hr)),  .seg_o(seg_hu));
    seg7_decoder u_dec_ht (.bcd_i(bcd_tens(disp_hr)),   .seg_o(seg_ht));

    assign {a_s_u, b_s_u, c_s_u, d_s_u, e_s_u, f_s_u, g_s_u} = seg_su;
    assign {a_s_t, b_s_t, c_s_t, d_s_t, e_s_t, f_s_t, g_s_t} = seg_st;
    assign {a_m_u, b_m_u, c_m_u, d_m_u, e_m_u, f_m_u, g_m_u} = seg_mu;
    assign {a_m_t, b_m_t, c_m_t, d_m_t, e_m_t, f_m_t, g_m_t} = seg_mt;
    assign {a_h_u, b_h_u, c_h_u, d_h_u, e_h_u, f_h_u, g_h_u} = seg_hu;
    assign {a_h_t, b_h_t, c_h_t, d_h_t, e_h_t, f_h_t, g_h_t} = seg_ht;

endmodule

// File: tb/tb_clock_alarm.sv
// Directed bench for clock_alarm with TICK_DIV=10: counting, setting, rollover,
// alarm ring/clear and asynchronous reset, checked against hand-computed displays.
module tb_clock_alarm;

    logic clk, reset, Set_Clock, Set_Alarm, Alarm_Off, MIN, HR;
    logic a_s_u, b_s_u, c_s_u, d_s_u, e_s_u, f_s_u, g_s_u;
    logic a_s_t, b_s_t, c_s_t, d_s_t, e_s_t, f_s_t, g_s_t;
    logic a_m_u, b_m_u, c_m_u, d_m_u, e_m_u, f_m_u, g_m_u;
    logic a_m_t, b_m_t, c_m_t, d_m_t, e_m_t, f_m_t, g_m_t;
    logic a_h_u, b_h_u, c_h_u, d_h_u, e_h_u, f_h_u, g_h_u;
    logic a_h_t, b_h_t, c_h_t, d_h_t, e_h_t, f_h_t, g_h_t;
    logic Alarm;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    clock_alarm #(.TICK_DIV(10)) dut (
        .clk(clk), .reset(reset), .Set_Clock(Set_Clock), .Set_Alarm(Set_Alarm),
        .Alarm_Off(Alarm_Off), .MIN(MIN), .HR(HR),
        .a_s_u(a_s_u), .b_s_u(b_s_u), .c_s_u(c_s_u), .d_s_u(d_s_u), .e_s_u(e_s_u), .f_s_u(f_s_u), .g_s_u(g_s_u),
        .a_s_t(a_s_t), .b_s_t(b_s_t), .c_s_t(c_s_t), .d_s_t(d_s_t), .e_s_t(e_s_t), .f_s_t(f_s_t), .g_s_t(g_s_t),
        .a_m_u(a_m_u), .b_m_u(b_m_u), .c_m_u(c_m_u), .d_m_u(d_m_u), .e_m_u(e_m_u), .f_m_u(f_m_u), .g_m_u(g_m_u),
        .a_m_t(a_m_t), .b_m_t(b_m_t), .c_m_t(c_m_t), .d_m_t(d_m_t), .e_m_t(e_m_t), .f_m_t(f_m_t), .g_m_t(g_m_t),
        .a_h_u(a_h_u), .b_h_u(b_h_u), .c_h_u(c_h_u), .d_h_u(d_h_u), .e_h_u(e_h_u), .f_h_u(f_h_u), .g_h_u(g_h_u),
        .a_h_t(a_h_t), .b_h_t(b_h_t), .c_h_t(c_h_t), .d_h_t(d_h_t), .e_h_t(e_h_t), .f_h_t(f_h_t), .g_h_t(g_h_t),
        .Alarm(Alarm)
    );

    logic [41:0] disp;
    assign disp = {a_h_t, b_h_t, c_h_t, d_h_t, e_h_t, f_h_t, g_h_t,
                   a_h_u, b_h_u, c_h_u, d_h_u, e_h_u, f_h_u, g_h_u,
                   a_m_t, b_m_t, c_m_t, d_m_t, e_m_t, f_m_t, g_m_t,
                   a_m_u, b_m_u, c_m_u, d_m_u, e_m_u, f_m_u, g_m_u,
                   a_s_t, b_s_t, c_s_t, d_s_t, e_s_t, f_s_t, g_s_t,
                   a_s_u, b_s_u, c_s_u, d_s_u, e_s_u, f_s_u, g_s_u};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] exp_disp(input int h, input int m, input int s);
        return {seg_of(h / 10), seg_of(h % 10), seg_of(m / 10), seg_of(m % 10),
                seg_of(s / 10), seg_of(s % 10)};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin
            MIN = 1'b1; cycles(1);
            MIN = 1'b0; cycles(1);
        end
    endtask

    task automatic pulse_hr(input int n);
        repeat (n) begin
            HR = 1'b1; cycles(1);
            HR = 1'b0; cycles(1);
        end
    endtask

    task automatic test_reset_count;
        cycles(2);
        chk_cnt++;
        if (disp !== exp_disp(0, 0, 0)) $display("FAIL reset_disp: got %h exp %h", disp, exp_disp(0, 0, 0));
        else pass_cnt++;
        chk_cnt++;
        if (Alarm !== 1'b0) $display("FAIL reset_alarm: got %b exp 0", Alarm);
        else pass_cnt++;
        reset = 1'b1;
        cycles(9);
        chk_cnt++;
        if (disp !== exp_disp(0, 0, 0)) $display("FAIL count_9cyc: got %h exp %h", disp, exp_disp(0, 0, 0));
        else pass_cnt++;
        cycles(1);
        chk_cnt++;
        if (disp !== exp_disp(0, 0, 1)) $display("FAIL count_10cyc: got %h exp %h", disp, exp_disp(0, 0, 1));
        else pass_cnt++;
        cycles(80);
        chk_cnt++;
        if (disp !== exp_disp(0, 0, 9)) $display("FAIL count_90cyc: got %h exp %h", disp, exp_disp(0, 0, 9));
        else pass_cnt++;
        cycles(10);
        chk_cnt++;
        if (disp !== exp_disp(0, 0, 10)) $display("FAIL count_100cyc: got %h exp %h", disp, exp_disp(0, 0, 10));
        else pass_cnt++;
    endtask

    task automatic test_set_clock;
        Set_Clock = 1'b1;
        cycles(1);
        chk_cnt++;
        if (disp !== exp_disp(0, 0, 0)) $display("FAIL setclk_sec0: got %h exp %h", disp, exp_disp(0, 0, 0));
        else pass_cnt++;
        pulse_min(61);
        chk_cnt++;
        if (disp !== exp_disp(0, 1, 0)) $display("FAIL setclk_61min: got %h exp %h", disp, exp_disp(0, 1, 0));
        else pass_cnt++;
        MIN = 1'b1; cycles(20);
        MIN = 1'b0; cycles(1);
        chk_cnt++;
        if (disp !== exp_disp(0, 2, 0)) $display("FAIL setclk_held: got %h exp %h", disp, exp_disp(0, 2, 0));
        else pass_cnt++;
        MIN = 1'b1; HR = 1'b1; cycles(1);
        MIN = 1'b0; HR = 1'b0; cycles(1);
        chk_cnt++;
        if (disp !== exp_disp(1, 3, 0)) $display("FAIL setclk_both: got %h exp %h", disp, exp_disp(1, 3, 0));
        else pass_cnt++;
        Set_Clock = 1'b0;
        pulse_min(1);
        chk_cnt++;
        if (disp !== exp_disp(1, 3, 0)) $display("FAIL idle_edge_ignored: got %h exp %h", disp, exp_disp(1, 3, 0));
        else pass_cnt++;
    endtask

    // Continues from test_set_clock: 2 cycles already elapsed since Set_Clock dropped.
    task automatic test_alarm_set;
        Set_Alarm = 1'b1;
        cycles(1);
        chk_cnt++;
        if (disp !== exp_disp(0, 0, 0)) $display("FAIL alset_show: got %h exp %h", disp, exp_disp(0, 0, 0));
        else pass_cnt++;
        pulse_hr(7);
        pulse_min(30);
        chk_cnt++;
        if (disp !== exp_disp(7, 30, 0)) $display("FAIL alset_0730: got %h exp %h", disp, exp_disp(7, 30, 0));
        else pass_cnt++;
        Set_Alarm = 1'b0;
        cycles(1);
        chk_cnt++;
        if (disp !== exp_disp(1, 3, 7)) $display("FAIL alset_time_ran: got %h exp %h", disp, exp_disp(1, 3, 7));
        else pass_cnt++;
    endtask

    task automatic test_rollover;
        Set_Clock = 1'b1;
        cycles(1);
        pulse_min(56);
        chk_cnt++;
        if (disp !== exp_disp(1, 59, 0)) $display("FAIL roll_min59: got %h exp %h", disp, exp_disp(1, 59, 0));
        else pass_cnt++;
        pulse_min(1);
        chk_cnt++;
        if (disp !== exp_disp(1, 0, 0)) $display("FAIL roll_min_wrap: got %h exp %h", disp, exp_disp(1, 0, 0));
        else pass_cnt++;
        pulse_min(59);
        pulse_hr(22);
        chk_cnt++;
        if (disp !== exp_disp(23, 59, 0)) $display("FAIL roll_2359: got %h exp %h", disp, exp_disp(23, 59, 0));
        else pass_cnt++;
        pulse_hr(1);
        chk_cnt++;
        if (disp !== exp_disp(0, 59, 0)) $display("FAIL roll_hr_wrap: got %h exp %h", disp, exp_disp(0, 59, 0));
        else pass_cnt++;
        pulse_hr(23);
        Set_Clock = 1'b0;
        cycles(599);
        chk_cnt++;
        if (disp !== exp_disp(23, 59, 59)) $display("FAIL roll_235959: got %h exp %h", disp, exp_disp(23, 59, 59));
        else pass_cnt++;
        cycles(1);
        chk_cnt++;
        if (disp !== exp_disp(0, 0, 0)) $display("FAIL roll_midnight: got %h exp %h", disp, exp_disp(0, 0, 0));
        else pass_cnt++;
        chk_cnt++;
        if (Alarm !== 1'b0) $display("FAIL roll_no_alarm: got %b exp 0", Alarm);
        else pass_cnt++;
    endtask

    task automatic test_alarm_fire;
        reset = 1'b0;
        cycles(1);
        Set_Alarm = 1'b1;
        reset = 1'b1;
        pulse_min(1);
        Set_Alarm = 1'b0;
        cycles(597);
        chk_cnt++;
        if (Alarm !== 1'b0) $display("FAIL fire_before: got %b exp 0", Alarm);
        else pass_cnt++;
        chk_cnt++;
        if (disp !== exp_disp(0, 0, 59)) $display("FAIL fire_before_disp: got %h exp %h", disp, exp_disp(0, 0, 59));
        else pass_cnt++;
        cycles(1);
        chk_cnt++;
        if (Alarm !== 1'b1) $display("FAIL fire_tick60: got %b exp 1", Alarm);
        else pass_cnt++;
        chk_cnt++;
        if (disp !== exp_disp(0, 1, 0)) $display("FAIL fire_disp: got %h exp %h", disp, exp_disp(0, 1, 0));
        else pass_cnt++;
        Set_Clock = 1'b1;
        cycles(2);
        Set_Clock = 1'b0;
        cycles(3);
        chk_cnt++;
        if (Alarm !== 1'b1) $display("FAIL fire_held: got %b exp 1", Alarm);
        else pass_cnt++;
        Alarm_Off = 1'b1;
        cycles(1);
        chk_cnt++;
        if (Alarm !== 1'b0) $display("FAIL clear_next: got %b exp 0", Alarm);
        else pass_cnt++;
        Set_Alarm = 1'b1;
        pulse_min(1);
        Set_Alarm = 1'b0;
        cycles(594);
        chk_cnt++;
        if (disp !== exp_disp(0, 2, 0)) $display("FAIL suppress_disp: got %h exp %h", disp, exp_disp(0, 2, 0));
        else pass_cnt++;
        chk_cnt++;
        if (Alarm !== 1'b0) $display("FAIL suppress_match: got %b exp 0", Alarm);
        else pass_cnt++;
        Alarm_Off = 1'b0;
        cycles(1);
        chk_cnt++;
        if (Alarm !== 1'b0) $display("FAIL suppress_after: got %b exp 0", Alarm);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        reset = 1'b0;
        cycles(1);
        Set_Alarm = 1'b1;
        reset = 1'b1;
        pulse_min(1);
        Set_Alarm = 1'b0;
        cycles(628);
        chk_cnt++;
        if (Alarm !== 1'b1 || disp !== exp_disp(0, 1, 3))
            $display("FAIL arst_pre: got alarm %b disp %h exp alarm 1 disp %h", Alarm, disp, exp_disp(0, 1, 3));
        else pass_cnt++;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk_cnt++;
        if (disp !== exp_disp(0, 0, 0)) $display("FAIL arst_disp: got %h exp %h", disp, exp_disp(0, 0, 0));
        else pass_cnt++;
        chk_cnt++;
        if (Alarm !== 1'b0) $display("FAIL arst_alarm: got %b exp 0", Alarm);
        else pass_cnt++;
        cycles(2);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        Set_Clock = 1'b0;
        Set_Alarm = 1'b0;
        Alarm_Off = 1'b0;
        MIN       = 1'b0;
        HR        = 1'b0;
        test_reset_count();
        test_set_clock();
        test_alarm_set();
        test_rollover();
        test_alarm_fire();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/clock_alarm.md
Name: clock_alarm

Overview:
- 24-hour digital clock (HH:MM:SS) with one programmable alarm (HH:MM).
- Drives six 7-segment digits: seconds, minutes and hours, each as units and tens.
- Time and alarm are set with push-button-style MIN/HR inputs while a Set mode is held.
- Top-level board block; a prescaler derives the 1 s tick from the system clock.

Parameters:
- TICK_DIV, 50_000_000: system-clock cycles per 1 s tick; must be >= 2; benches override it with a small value.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Set_Clock  input  1  level; while high, MIN/HR edit the time.
- Set_Alarm  input  1  level; while high (and Set_Clock low), display and edit the alarm.
- Alarm_Off  input  1  level; high clears the ringing alarm and suppresses it.
- MIN  input  1  level; each rising edge increments minutes in the active set mode.
- HR  input  1  level; each rising edge increments hours in the active set mode.
- a_s_u..g_s_u  output  1 each  segments a-g of the seconds units digit.
- a_s_t..g_s_t  output  1 each  segments of the seconds tens digit.
- a_m_u..g_m_u, a_m_t..g_m_t  output  1 each  segments of the minutes units and tens digits.
- a_h_u..g_h_u, a_h_t..g_h_t  output  1 each  segments of the hours units and tens digits.
- Alarm  output  1  high while the alarm is ringing.

Behaviour:
- Reset (reset=0, asynchronous):
  - time = 00:00:00, alarm = 00:00, prescaler = 0, Alarm = 0, edge registers = 0.
  - Segments show "000000".
- Segments are active-low (0 = lit), standard patterns for 0-9; a = top, clockwise to f, g = middle.
- Counters are binary: sec 0-59, min 0-59, hr 0-23. They are split into tens/units combinationally for display, with no register latency.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick is a 1-cycle pulse when it wraps.
  - Held at 0 while Set_Clock=1.
- Normal mode (Set_Clock=0):
  - On tick, sec increments.
  - 59 -> 0 with carry to min; min 59 -> 0 with carry to hr; hr 23 -> 0.
  - 23:59:59 -> 00:00:00.
  - Time keeps running while Set_Alarm=1.
- MIN and HR are registered once per cycle; a rising edge is a cycle where the input is 1 and the stored value is 0. One increment per edge.
- Set_Clock=1 (priority over Set_Alarm):
  - sec forced to 0.
  - MIN edge: time min +1, 59 -> 0, no carry into hr.
  - HR edge: time hr +1, 23 -> 0.
  - MIN and HR edges in the same cycle both apply.
- Set_Alarm=1 with Set_Clock=0:
  - Display shows alarm hr:min with seconds "00".
  - MIN/HR edges edit the alarm with the same wrap rules.
  - Time keeps counting underneath.
- Display in all other cases: current time.
- Alarm trigger:
  - Sets Alarm=1 on the tick that makes time equal alarm_hr:alarm_min:00, and only if Alarm_Off=0.
  - Edits under Set_Clock never trigger, so reset to 00:00:00 does not ring.
- Alarm clear:
  - Alarm_Off=1 clears Alarm on the next clk edge and blocks any trigger while high.
  - Alarm otherwise stays 1 until Alarm_Off is asserted or reset.
  - Entering Set_Clock does not clear Alarm.
- Edit edges that arrive while neither set mode is active are ignored.
- Reset mid-operation returns every state to its reset value immediately.

Decomposition:
- Package clock_alarm_pkg holds:
  - SEG_0..SEG_9 and SEG_OFF 7-bit active-low constants, bit order {a,b,c,d,e,f,g}.
  - Limits SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
- Sub-module seg7_decoder: 4-bit BCD in, 7-bit segments out; values above 9 give SEG_OFF.
- seg7_decoder is instantiated six times in the top.
- Prescaler, counters, edge detect and alarm logic stay in the top.

Test Plan:
1. Reset and count with TICK_DIV=10:
   - Hold reset=0 for 2 cycles -> all digits show "0" (0000001 pattern), Alarm=0.
   - Release -> seconds units shows 1 after 10 cycles and 9 after 90; sec tens becomes 1 after 100 cycles.
2. Rollover: set time to 23:59 via Set_Clock with 23 HR edges and 59 MIN edges, then release -> after 60 ticks display "000000", no alarm.
3. Set_Clock edits:
   - 61 MIN edges -> min=01 and hr unchanged.
   - MIN held high for 20 cycles counts once.
   - Seconds stay 00 while Set_Clock=1.
4. Alarm set: Set_Alarm=1 with 7 HR and 30 MIN edges -> display "073000", time keeps counting; release -> display returns to time.
5. Alarm fire and clear:
   - Alarm 00:01, run from reset -> Alarm rises on tick 60, time 00:01:00.
   - Alarm_Off=1 -> Alarm=0 next cycle; it stays 0 while Alarm_Off remains high across a repeat match.
6. Asynchronous reset: assert reset=0 mid-count between clk edges -> outputs go to "000000" and Alarm=0 without waiting for a clk edge.
